timer8_apb_core: RTL and testbench

//  8-bit up/down timer/counter with an integrated clock prescaler and an APB slave register interface.

---
 rtl/timer8_apb_core_if.sv | 16 +
 rtl/timer8_apb_core.sv | 81 ++++++++
 tb/tb_timer8_apb_core.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/timer8_apb_core_if.sv
// timer8_apb_core_if: APB slave bus bundle for one timer channel.
interface timer8_apb_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;
    modport master(output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/timer8_apb_core.sv
// timer8_apb_core: 8-bit up/down timer with clock-enable prescaler, sticky OVF/UDF flags and APB registers.
module timer8_apb_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    timer8_apb_core_if.slave     apb,
    output logic                 TMR_OVF,
    output logic                 TMR_UDF
);
    localparam logic [ADDR_WIDTH-1:0] A_TDR  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_TCR  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_TSR  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_TCNT = ADDR_WIDTH'(5);
    localparam logic [DATA_WIDTH-1:0] TCR_MASK = DATA_WIDTH'(8'hB3);

    logic [DATA_WIDTH-1:0] r_tdr, r_tcr, r_tcnt;
    logic [1:0]            r_tsr;
    logic [3:0]            r_pc;
    logic                  r_tmr_ovf, r_tmr_udf;

    logic                  w_access, w_wr;
    logic                  w_sel_tdr, w_sel_tcr, w_sel_tsr, w_sel_tcnt;
    logic [3:0]            w_mask;
    logic                  w_tick, w_up, w_dn;
    logic [1:0]            w_set, w_clr;
    logic [DATA_WIDTH-1:0] w_rdata, w_tcnt_nxt;

    assign w_access   = apb.psel & apb.penable;
    assign w_wr       = w_access & apb.pwrite;
    assign w_sel_tdr  = apb.paddr == A_TDR;
    assign w_sel_tcr  = apb.paddr == A_TCR;
    assign w_sel_tsr  = apb.paddr == A_TSR;
    assign w_sel_tcnt = apb.paddr == A_TCNT;

    // Tick when the low cks+1 prescaler bits are all ones; mask bits above that are forced high.
    assign w_mask = {&r_tcr[1:0], r_tcr[1], |r_tcr[1:0], 1'b1};
    assign w_tick = &(r_pc | ~w_mask);
    assign w_up   = ~r_tcr[7] & r_tcr[4] & w_tick & ~r_tcr[5];
    assign w_dn   = ~r_tcr[7] & r_tcr[4] & w_tick & r_tcr[5];
    assign w_set  = {w_dn & ~|r_tcnt, w_up & &r_tcnt};
    assign w_clr  = (w_wr & w_sel_tsr) ? apb.pwdata[1:0] : 2'b00;

    always_comb begin
        w_tcnt_nxt = r_tcr[7] ? r_tdr :
                     w_up     ? r_tcnt + DATA_WIDTH'(1) :
                     w_dn     ? r_tcnt - DATA_WIDTH'(1) : r_tcnt;
        w_rdata    = w_sel_tdr  ? r_tdr :
                     w_sel_tcr  ? r_tcr :
                     w_sel_tsr  ? {{(DATA_WIDTH-2){1'b0}}, r_tsr} :
                     w_sel_tcnt ? r_tcnt : '0;
    end

    assign apb.prdata  = (apb.psel & ~apb.pwrite) ? w_rdata : '0;
    assign apb.pready  = w_access;
    assign apb.pslverr = w_access & (~(w_sel_tdr | w_sel_tcr | w_sel_tsr | w_sel_tcnt) | (apb.pwrite & w_sel_tcnt));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_tdr     <= '0;
            r_tcr     <= '0;
            r_tsr     <= '0;
            r_tcnt    <= '0;
            r_pc      <= '0;
            r_tmr_ovf <= 1'b0;
            r_tmr_udf <= 1'b0;
        end else begin
            r_pc      <= r_pc + 4'd1;
            r_tcnt    <= w_tcnt_nxt;
            r_tsr     <= (r_tsr & ~w_clr) | w_set;
            r_tmr_ovf <= r_tsr[0];
            r_tmr_udf <= r_tsr[1];
            if (w_wr & w_sel_tdr) r_tdr <= apb.pwdata;
            if (w_wr & w_sel_tcr) r_tcr <= apb.pwdata & TCR_MASK;
        end
    end

    assign TMR_OVF = r_tmr_ovf;
    assign TMR_UDF = r_tmr_udf;
endmodule

// File: tb/tb_timer8_apb_core.sv
// tb_timer8_apb_core: directed self-checking bench for two timer channels sharing one APB segment.
module tb_timer8_apb_core;
    logic       pclk = 1'b0;
    logic       preset_n;
    logic       psel0, psel1, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic       ovf0, udf0, ovf1, udf1;
    int         n_checks = 0;
    int         n_fail = 0;

    timer8_apb_core_if bus0 ();
    timer8_apb_core_if bus1 ();

    assign bus0.psel    = psel0;
    assign bus1.psel    = psel1;
    assign bus0.penable = penable;
    assign bus1.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus1.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus1.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus1.pwdata  = pwdata;

    timer8_apb_core u0 (.pclk(pclk), .preset_n(preset_n), .apb(bus0), .TMR_OVF(ovf0), .TMR_UDF(udf0));
    timer8_apb_core u1 (.pclk(pclk), .preset_n(preset_n), .apb(bus1), .TMR_OVF(ovf1), .TMR_UDF(udf1));

    always #5 pclk = ~pclk;

    // Called at a falling edge; the commit happens on the second rising edge after the call.
    task automatic apb_write(input logic [1:0] sel, input logic [2:0] a, input logic [7:0] d, output logic err);
        {psel1, psel0} = sel;
        pwrite  = 1'b1;
        paddr   = a;
        pwdata  = d;
        penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1 err = sel[0] ? bus0.pslverr : bus1.pslverr;
        @(negedge pclk);
        {psel1, psel0, penable, pwrite} = 4'b0;
    endtask

    // Read data is captured in the setup phase, i.e. at the falling edge the task is called on.
    task automatic apb_read(input int u, input logic [2:0] a, output logic [7:0] d, output logic err, output logic rdy);
        psel0   = (u == 0);
        psel1   = (u == 1);
        pwrite  = 1'b0;
        paddr   = a;
        penable = 1'b0;
        #1 d = u ? bus1.prdata : bus0.prdata;
        @(negedge pclk);
        penable = 1'b1;
        #1 err = u ? bus1.pslverr : bus0.pslverr;
        rdy = u ? bus1.pready : bus0.pready;
        @(negedge pclk);
        {psel1, psel0, penable} = 3'b0;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic e, r;
        preset_n = 1'b0;
        repeat (3) @(negedge pclk);
        n_checks++; if ({ovf0, udf0, ovf1, udf1} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {ovf0, udf0, ovf1, udf1}); end
        n_checks++; if (bus0.pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready got %b exp 0", bus0.pready); end
        preset_n = 1'b1;
        @(negedge pclk);
        for (int a = 2; a <= 5; a++) begin
            apb_read(0, 3'(a), d, e, r);
            n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_read[%0d] got %h exp 00", a, d); end
            n_checks++; if ({e, r} !== 2'b01) begin n_fail++; $display("FAIL reset_resp[%0d] got err=%b rdy=%b exp err=0 rdy=1", a, e, r); end
        end
    endtask

    task automatic test_rw;
        logic [7:0] d;
        logic e, r;
        apb_write(2'b01, 3'd2, 8'hA5, e);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL tdr_wr_err got %b exp 0", e); end
        apb_read(0, 3'd2, d, e, r);
        n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL tdr_rd got %h exp a5", d); end
        apb_write(2'b01, 3'd3, 8'h4C, e);
        apb_read(0, 3'd3, d, e, r);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL tcr_reserved got %h exp 00", d); end
    endtask

    task automatic test_unmapped;
        logic [7:0] d;
        logic e, r;
        apb_read(0, 3'd0, d, e, r);
        n_checks++; if ({d, e} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL unmapped_rd0 got data=%h err=%b exp data=00 err=1", d, e); end
        apb_read(0, 3'd7, d, e, r);
        n_checks++; if ({d, e} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL unmapped_rd7 got data=%h err=%b exp data=00 err=1", d, e); end
        apb_write(2'b01, 3'd1, 8'h11, e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmapped_wr got %b exp 1", e); end
    endtask

    task automatic test_count_up;
        logic [7:0] d;
        logic e, r;
        apb_write(2'b01, 3'd2, 8'hF0, e);
        apb_write(2'b01, 3'd3, 8'h80, e);
        apb_write(2'b01, 3'd3, 8'h10, e);
        repeat (16) @(negedge pclk);
        apb_read(0, 3'd5, d, e, r);
        n_checks++; if (d !== 8'hF8) begin n_fail++; $display("FAIL up_mid got %h exp f8", d); end
        repeat (14) @(negedge pclk);
        apb_read(0, 3'd5, d, e, r);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL up_wrap got %h exp 00", d); end
        n_checks++; if ({ovf0, udf0} !== 2'b10) begin n_fail++; $display("FAIL up_flags got ovf=%b udf=%b exp ovf=1 udf=0", ovf0, udf0); end
    endtask

    task automatic test_count_down;
        logic [7:0] d;
        logic e, r;
        apb_write(2'b01, 3'd2, 8'h03, e);
        apb_write(2'b01, 3'd3, 8'h80, e);
        apb_write(2'b01, 3'd3, 8'h31, e);
        repeat (16) @(negedge pclk);
        apb_read(0, 3'd5, d, e, r);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL down_wrap got %h exp ff", d); end
        n_checks++; if ({ovf0, udf0} !== 2'b11) begin n_fail++; $display("FAIL down_flags got ovf=%b udf=%b exp ovf=1 udf=1", ovf0, udf0); end
    endtask

    task automatic test_w1c;
        logic [7:0] d;
        logic e, r;
        apb_write(2'b01, 3'd4, 8'h01, e);
        @(negedge pclk);
        n_checks++; if ({ovf0, udf0} !== 2'b01) begin n_fail++; $display("FAIL w1c_flags got ovf=%b udf=%b exp ovf=0 udf=1", ovf0, udf0); end
        apb_read(0, 3'd4, d, e, r);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL w1c_tsr got %h exp 02", d); end
    endtask

    task automatic test_freeze;
        logic [7:0] d;
        logic e, r;
        apb_write(2'b01, 3'd3, 8'h00, e);
        apb_write(2'b01, 3'd2, 8'h10, e);
        apb_write(2'b01, 3'd3, 8'h80, e);
        apb_write(2'b01, 3'd3, 8'h30, e);
        repeat (6) @(negedge pclk);
        apb_write(2'b01, 3'd3, 8'h00, e);
        repeat (20) @(negedge pclk);
        apb_read(0, 3'd5, d, e, r);
        n_checks++; if (d !== 8'h0C) begin n_fail++; $display("FAIL freeze got %h exp 0c", d); end
        apb_write(2'b01, 3'd5, 8'h55, e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL tcnt_wr_err got %b exp 1", e); end
        apb_read(0, 3'd5, d, e, r);
        n_checks++; if (d !== 8'h0C) begin n_fail++; $display("FAIL tcnt_ro got %h exp 0c", d); end
        n_checks++; if (udf0 !== 1'b1) begin n_fail++; $display("FAIL freeze_flag got %b exp 1", udf0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic e, r;
        apb_write(2'b01, 3'd4, 8'h03, e);
        apb_write(2'b01, 3'd2, 8'h10, e);
        apb_write(2'b10, 3'd2, 8'hFE, e);
        apb_write(2'b11, 3'd3, 8'h80, e);
        apb_write(2'b11, 3'd3, 8'h10, e);
        repeat (8) @(negedge pclk);
        apb_read(0, 3'd5, d, e, r);
        n_checks++; if (d !== 8'h14) begin n_fail++; $display("FAIL inst0_cnt got %h exp 14", d); end
        apb_read(1, 3'd5, d, e, r);
        n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL inst1_cnt got %h exp 03", d); end
        n_checks++; if ({ovf0, udf0, ovf1, udf1} !== 4'b0010) begin n_fail++; $display("FAIL inst_flags got %b exp 0010", {ovf0, udf0, ovf1, udf1}); end
    endtask

    task automatic test_async_reset;
        psel1  = 1'b1;
        pwrite = 1'b0;
        paddr  = 3'd5;
        #1 preset_n = 1'b0;
        #1;
        n_checks++; if (bus1.prdata !== 8'h00) begin n_fail++; $display("FAIL async_rst_cnt got %h exp 00", bus1.prdata); end
        n_checks++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL async_rst_ovf got %b exp 0", ovf1); end
        psel1 = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
    endtask

    initial begin
        {psel0, psel1, penable, pwrite} = 4'b0;
        paddr  = '0;
        pwdata = '0;
        test_reset();
        test_rw();
        test_unmapped();
        test_count_up();
        test_count_down();
        test_w1c();
        test_freeze();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
